// File: rtl/ftdi_tx_if.sv
// Message handshake between a producer and the FTDI transmit path.
// The producer drives the master side; ftdi_tx is the slave.
interface ftdi_tx_if;
   logic        msg_valid;
   logic        msg_ready;
   logic [3:0]  msg_type;
   logic [31:0] msg_data;

   modport master (
      output msg_valid,
      output msg_type,
      output msg_data,
      input  msg_ready
   );

   modport slave (
      input  msg_valid,
      input  msg_type,
      input  msg_data,
      output msg_ready
   );
endinterface

// File: rtl/ftdi_tx.sv
// FTDI synchronous-FIFO transmit path.
// Buffers 36-bit messages and sends each as a 7-byte checksummed frame.
module ftdi_tx #(
   parameter int          FIFO_AW   = 2,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5,
   parameter int          STALL_MAX = 1023
) (
   input  logic        ft_clk,
   input  logic        rst,
   ftdi_tx_if.slave    msg,
   input  logic        rx_busy,
   output logic        tx_busy,
   input  logic        ft_txe,
   output logic        ft_wr,
   output logic [7:0]  ft_d_out,
   output logic        ft_d_oe,
   output logic [15:0] tx_frames,
   output logic        stall_err
);

   localparam int DEPTH = 2 ** FIFO_AW;
   localparam int SW    = $clog2(STALL_MAX + 1);
   localparam logic [SW-1:0] STALL_TOP  = SW'(STALL_MAX);
   localparam logic [SW-1:0] STALL_LAST = SW'(STALL_MAX - 1);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      GAP
   } state_t;

   state_t state, state_n;

   logic [35:0]      mem [DEPTH];
   logic [FIFO_AW:0] wr_ptr, rd_ptr;
   logic             empty, full, push, start;
   logic             accept, last;

   logic [3:0]       seq;
   logic [3:0]       sh_type;
   logic [31:0]      sh_data;
   logic [2:0]       idx, idx_n;
   logic [7:0]       nxt_byte, csum;
   logic [SW-1:0]    stall_cnt;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                  (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);

   assign msg.msg_ready = ~full;
   assign push  = msg.msg_valid & ~full;
   assign start = (state == IDLE) & ~empty & ~rx_busy;

   // ft_wr is only ever low while in SEND
   assign accept = (state == SEND) & ~ft_wr & ~ft_txe;
   assign last   = accept & (idx == 3'd6);
   assign idx_n  = idx + 3'd1;

   assign csum = {seq, sh_type} ^ sh_data[7:0] ^ sh_data[15:8] ^
                 sh_data[23:16] ^ sh_data[31:24];

   always_comb begin
      nxt_byte = SYNC_BYTE;
      unique case (idx_n)
         3'd1:    nxt_byte = {seq, sh_type};
         3'd2:    nxt_byte = sh_data[7:0];
         3'd3:    nxt_byte = sh_data[15:8];
         3'd4:    nxt_byte = sh_data[23:16];
         3'd5:    nxt_byte = sh_data[31:24];
         3'd6:    nxt_byte = csum;
         default: nxt_byte = SYNC_BYTE;
      endcase
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (start) state_n = SEND;
         SEND:    if (last)  state_n = GAP;
         GAP:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge ft_clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_ff @(posedge ft_clk) begin
      if (push) mem[wr_ptr[FIFO_AW-1:0]] <= {msg.msg_type, msg.msg_data};
   end

   always_ff @(posedge ft_clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push)  wr_ptr <= wr_ptr + 1'b1;
         if (start) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge ft_clk or posedge rst) begin
      if (rst) begin
         sh_type   <= '0;
         sh_data   <= '0;
         idx       <= '0;
         seq       <= '0;
         ft_wr     <= 1'b1;
         ft_d_out  <= '0;
         ft_d_oe   <= 1'b0;
         tx_busy   <= 1'b0;
         tx_frames <= '0;
      end else if (start) begin
         {sh_type, sh_data} <= mem[rd_ptr[FIFO_AW-1:0]];
         idx      <= '0;
         ft_wr    <= 1'b0;
         ft_d_oe  <= 1'b1;
         ft_d_out <= SYNC_BYTE;
         tx_busy  <= 1'b1;
      end else if (last) begin
         ft_wr     <= 1'b1;
         ft_d_oe   <= 1'b0;
         tx_busy   <= 1'b0;
         tx_frames <= tx_frames + 16'd1;
         seq       <= seq + 4'd1;
      end else if (accept) begin
         idx      <= idx_n;
         ft_d_out <= nxt_byte;
      end
   end

   // stall count saturates; any accepted byte restarts it
   always_ff @(posedge ft_clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         stall_err <= 1'b0;
      end else if (accept) begin
         stall_cnt <= '0;
      end else if (state == SEND && ft_txe) begin
         if (stall_cnt != STALL_TOP) stall_cnt <= stall_cnt + 1'b1;
         if (stall_cnt == STALL_LAST) stall_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ftdi_tx.sv
// Directed self-checking bench for ftdi_tx.
// A monitor records every accepted byte with its edge number.
module tb_ftdi_tx;

   logic        ft_clk;
   logic        rst;
   logic        rx_busy;
   logic        tx_busy;
   logic        ft_txe;
   logic        ft_wr;
   logic [7:0]  ft_d_out;
   logic        ft_d_oe;
   logic [15:0] tx_frames;
   logic        stall_err;

   ftdi_tx_if msg_if ();

   ftdi_tx dut (
      .ft_clk    (ft_clk),
      .rst       (rst),
      .msg       (msg_if),
      .rx_busy   (rx_busy),
      .tx_busy   (tx_busy),
      .ft_txe    (ft_txe),
      .ft_wr     (ft_wr),
      .ft_d_out  (ft_d_out),
      .ft_d_oe   (ft_d_oe),
      .tx_frames (tx_frames),
      .stall_err (stall_err)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int push_cyc = 0;

   logic [7:0] bq [$];
   int         cq [$];

   initial ft_clk = 1'b0;
   always #5 ft_clk = ~ft_clk;

   always @(posedge ft_clk) begin
      if (!rst && !ft_wr && !ft_txe) begin
         bq.push_back(ft_d_out);
         cq.push_back(cyc);
      end
      cyc++;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge ft_clk);
         #1;
      end
   endtask

   task automatic do_reset;
      rst = 1'b1;
      msg_if.msg_valid = 1'b0;
      msg_if.msg_type  = '0;
      msg_if.msg_data  = '0;
      rx_busy = 1'b0;
      ft_txe  = 1'b1;
      step(2);
      rst = 1'b0;
      bq.delete();
      cq.delete();
   endtask

   task automatic push(input logic [3:0] t, input logic [31:0] d);
      int  n;
      logic took;
      n = 0;
      took = 1'b0;
      msg_if.msg_type  = t;
      msg_if.msg_data  = d;
      msg_if.msg_valid = 1'b1;
      while (!took && n < 2000) begin
         took = msg_if.msg_ready;
         step(1);
         n++;
      end
      msg_if.msg_valid = 1'b0;
      push_cyc = cyc - 1;
      if (!took) begin
         total++;
         bad++;
         $display("FAIL push_timeout: msg_ready never high, type=%h", t);
      end
   endtask

   task automatic expect_frame(input logic [3:0] s, input logic [3:0] t,
                               input logic [31:0] d, input bit consec,
                               output int first);
      logic [7:0] e [7];
      int n;
      n = 0;
      first = -1;
      e[0] = 8'hA5;
      e[1] = {s, t};
      e[2] = d[7:0];
      e[3] = d[15:8];
      e[4] = d[23:16];
      e[5] = d[31:24];
      e[6] = e[1] ^ e[2] ^ e[3] ^ e[4] ^ e[5];
      while (bq.size() < 7 && n < 3000) begin
         step(1);
         n++;
      end
      total++;
      if (bq.size() < 7) begin
         bad++;
         $display("FAIL frame_timeout: got %0d bytes, required 7", bq.size());
         return;
      end
      for (int i = 0; i < 7; i++) begin
         total++;
         if (bq[i] !== e[i]) begin
            bad++;
            $display("FAIL frame_byte%0d seq=%0d: got %h, required %h",
                     i, s, bq[i], e[i]);
         end
      end
      if (consec) begin
         total++;
         if (cq[6] - cq[0] != 6) begin
            bad++;
            $display("FAIL frame_span seq=%0d: got %0d edges, required 6",
                     s, cq[6] - cq[0]);
         end
      end
      first = cq[0];
      repeat (7) begin
         void'(bq.pop_front());
         void'(cq.pop_front());
      end
   endtask

   task automatic test_reset;
      do_reset();
      total++;
      if (msg_if.msg_ready !== 1'b1) begin
         bad++; $display("FAIL rst_ready: got %b, required 1", msg_if.msg_ready);
      end
      total++;
      if (tx_busy !== 1'b0) begin
         bad++; $display("FAIL rst_busy: got %b, required 0", tx_busy);
      end
      total++;
      if (ft_wr !== 1'b1) begin
         bad++; $display("FAIL rst_wr: got %b, required 1", ft_wr);
      end
      total++;
      if (ft_d_out !== 8'h00) begin
         bad++; $display("FAIL rst_dout: got %h, required 00", ft_d_out);
      end
      total++;
      if (ft_d_oe !== 1'b0) begin
         bad++; $display("FAIL rst_oe: got %b, required 0", ft_d_oe);
      end
      total++;
      if (tx_frames !== 16'd0) begin
         bad++; $display("FAIL rst_frames: got %0d, required 0", tx_frames);
      end
      total++;
      if (stall_err !== 1'b0) begin
         bad++; $display("FAIL rst_stall: got %b, required 0", stall_err);
      end
   endtask

   task automatic test_reset_mid;
      int n;
      int lows;
      do_reset();
      ft_txe = 1'b0;
      push(4'h2, 32'hA1B2C3D4);
      push(4'h3, 32'h01020304);
      n = 0;
      while (bq.size() < 3 && n < 50) begin
         step(1);
         n++;
      end
      total++;
      if (bq.size() < 3) begin
         bad++; $display("FAIL mid_wait: got %0d bytes, required 3", bq.size());
      end
      rst = 1'b1;
      step(1);
      total++;
      if (ft_wr !== 1'b1 || ft_d_oe !== 1'b0 || tx_busy !== 1'b0) begin
         bad++;
         $display("FAIL mid_rst_bus: got wr=%b oe=%b busy=%b, required 1 0 0",
                  ft_wr, ft_d_oe, tx_busy);
      end
      total++;
      if (tx_frames !== 16'd0) begin
         bad++; $display("FAIL mid_rst_frames: got %0d, required 0", tx_frames);
      end
      rst = 1'b0;
      bq.delete();
      cq.delete();
      lows = 0;
      repeat (12) begin
         step(1);
         if (ft_wr === 1'b0) lows++;
      end
      total++;
      if (lows != 0) begin
         bad++; $display("FAIL mid_fifo_empty: got %0d wr lows, required 0", lows);
      end
   endtask

   task automatic test_single;
      logic [7:0] e [7];
      int n;
      int base;
      e = '{8'hA5, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'h0A};
      do_reset();
      ft_txe = 1'b0;
      push(4'h2, 32'h12345678);
      base = push_cyc;
      step(1);
      total++;
      if (ft_wr !== 1'b0 || ft_d_out !== 8'hA5 || ft_d_oe !== 1'b1 ||
          tx_busy !== 1'b1) begin
         bad++;
         $display("FAIL single_first: got wr=%b d=%h oe=%b busy=%b, required 0 a5 1 1",
                  ft_wr, ft_d_out, ft_d_oe, tx_busy);
      end
      n = 0;
      while (bq.size() < 7 && n < 50) begin
         step(1);
         n++;
      end
      total++;
      if (bq.size() < 7) begin
         bad++; $display("FAIL single_wait: got %0d bytes, required 7", bq.size());
      end else begin
         for (int i = 0; i < 7; i++) begin
            total++;
            if (bq[i] !== e[i]) begin
               bad++;
               $display("FAIL single_byte%0d: got %h, required %h", i, bq[i], e[i]);
            end
         end
         total++;
         if (cq[0] != base + 2 || cq[6] != base + 8) begin
            bad++;
            $display("FAIL single_timing: got %0d..%0d, required %0d..%0d",
                     cq[0] - base, cq[6] - base, 2, 8);
         end
      end
      step(2);
      total++;
      if (tx_frames !== 16'd1 || tx_busy !== 1'b0 || ft_d_oe !== 1'b0) begin
         bad++;
         $display("FAIL single_end: got frames=%0d busy=%b oe=%b, required 1 0 0",
                  tx_frames, tx_busy, ft_d_oe);
      end
   endtask

   task automatic test_stall_hold;
      int n;
      int f;
      do_reset();
      ft_txe = 1'b0;
      push(4'h2, 32'h12345678);
      n = 0;
      while (!(ft_d_out === 8'h78 && ft_wr === 1'b0) && n < 50) begin
         step(1);
         n++;
      end
      ft_txe = 1'b1;
      step(3);
      total++;
      if (ft_d_out !== 8'h78 || ft_wr !== 1'b0) begin
         bad++;
         $display("FAIL hold_pins: got d=%h wr=%b, required 78 0", ft_d_out, ft_wr);
      end
      ft_txe = 1'b0;
      expect_frame(4'h0, 4'h2, 32'h12345678, 1'b0, f);
      step(3);
      total++;
      if (bq.size() != 0) begin
         bad++; $display("FAIL hold_extra: got %0d extra bytes, required 0", bq.size());
      end
      total++;
      if (stall_err !== 1'b0) begin
         bad++; $display("FAIL hold_stall: got %b, required 0", stall_err);
      end
   endtask

   task automatic test_fifo_full;
      int f [5];
      do_reset();
      ft_txe = 1'b1;
      for (int i = 0; i < 4; i++) push(4'(i + 8), 32'h11110000 + 32'(i));
      total++;
      if (msg_if.msg_ready !== 1'b1) begin
         bad++; $display("FAIL full_early: got ready=%b, required 1", msg_if.msg_ready);
      end
      push(4'hC, 32'h11110004);
      total++;
      if (msg_if.msg_ready !== 1'b0) begin
         bad++; $display("FAIL full_ready: got ready=%b, required 0", msg_if.msg_ready);
      end
      ft_txe = 1'b0;
      for (int i = 0; i < 5; i++)
         expect_frame(4'(i), 4'(i + 8), 32'h11110000 + 32'(i), i > 0, f[i]);
      for (int i = 2; i < 5; i++) begin
         total++;
         if (f[i] - f[i-1] != 9) begin
            bad++;
            $display("FAIL b2b_period%0d: got %0d, required 9", i, f[i] - f[i-1]);
         end
      end
   endtask

   task automatic test_rx_busy;
      int n;
      int lows;
      int f;
      do_reset();
      ft_txe  = 1'b0;
      rx_busy = 1'b1;
      push(4'h5, 32'hCAFEF00D);
      lows = 0;
      repeat (20) begin
         step(1);
         if (ft_wr === 1'b0) lows++;
      end
      total++;
      if (lows != 0) begin
         bad++; $display("FAIL rxb_block: got %0d wr lows, required 0", lows);
      end
      rx_busy = 1'b0;
      n = 0;
      while (ft_wr !== 1'b0 && n < 20) begin
         step(1);
         n++;
      end
      step(2);
      rx_busy = 1'b1;
      expect_frame(4'h0, 4'h5, 32'hCAFEF00D, 1'b1, f);
      step(2);
      total++;
      if (tx_frames !== 16'd1) begin
         bad++; $display("FAIL rxb_frames: got %0d, required 1", tx_frames);
      end
      rx_busy = 1'b0;
   endtask

   task automatic test_stall_err;
      int n;
      int f;
      do_reset();
      ft_txe = 1'b0;
      push(4'h7, 32'h89ABCDEF);
      n = 0;
      while (ft_wr !== 1'b0 && n < 20) begin
         step(1);
         n++;
      end
      ft_txe = 1'b1;
      step(1022);
      total++;
      if (stall_err !== 1'b0 || ft_wr !== 1'b0) begin
         bad++;
         $display("FAIL stall_1022: got err=%b wr=%b, required 0 0", stall_err, ft_wr);
      end
      step(1);
      total++;
      if (stall_err !== 1'b1) begin
         bad++; $display("FAIL stall_1023: got %b, required 1", stall_err);
      end
      ft_txe = 1'b0;
      expect_frame(4'h0, 4'h7, 32'h89ABCDEF, 1'b0, f);
      step(3);
      total++;
      if (stall_err !== 1'b1 || tx_frames !== 16'd1) begin
         bad++;
         $display("FAIL stall_sticky: got err=%b frames=%0d, required 1 1",
                  stall_err, tx_frames);
      end
   endtask

   task automatic test_seq_wrap;
      int f;
      do_reset();
      ft_txe = 1'b0;
      for (int i = 0; i < 17; i++)
         push(4'(i), {4{8'(i)}} ^ 32'hDEADBEEF);
      for (int i = 0; i < 17; i++)
         expect_frame(4'(i), 4'(i), {4{8'(i)}} ^ 32'hDEADBEEF, 1'b1, f);
      step(3);
      total++;
      if (tx_frames !== 16'd17) begin
         bad++; $display("FAIL wrap_frames: got %0d, required 17", tx_frames);
      end
   endtask

   initial begin
      rst = 1'b1;
      rx_busy = 1'b0;
      ft_txe = 1'b1;
      msg_if.msg_valid = 1'b0;
      msg_if.msg_type  = '0;
      msg_if.msg_data  = '0;
      test_reset();
      test_reset_mid();
      test_single();
      test_stall_hold();
      test_fifo_full();
      test_rx_busy();
      test_stall_err();
      test_seq_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
